axi_burst_write_master: RTL and testbench

- Parametrised successor to the single-burst miner result writer.
- Accepts one stream-to-memory job per ctrl_start. Splits it into multiple AXI4 INCR write bursts that never cross a 4 KiB boundary. Keeps up to C_MAX_OUTSTANDING bursts in flight.
- Buffers stream data in an internal FIFO and issues a burst's AW only once all of its beats are buffered.
- Sits between the miner result stream and the kernel's HBM/DDR AXI port. Reports completion and write-response errors to the kernel control block.

---
 rtl/axi_burst_write_master_if.sv | 43 ++++
 rtl/axi_burst_write_master.sv | 159 +++++++++++++++
 tb/tb_axi_burst_write_master.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_write_master_if.sv
// rtl/axi_burst_write_master_if.sv - AXI4 write channels plus input stream of the burst write master
interface axi_burst_write_master_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [7:0]              m_axi_awlen;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wlast;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;
  logic [1:0]              m_axi_bresp;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic [DATA_WIDTH-1:0]   s_axis_tdata;

  modport master (
    output m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
    input  m_axi_awready,
    output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    input  m_axi_wready,
    input  m_axi_bvalid, m_axi_bresp,
    output m_axi_bready,
    input  s_axis_tvalid, s_axis_tdata,
    output s_axis_tready
  );

  modport slave (
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
    output m_axi_awready,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    output m_axi_wready,
    output m_axi_bvalid, m_axi_bresp,
    input  m_axi_bready,
    output s_axis_tvalid, s_axis_tdata,
    input  s_axis_tready
  );
endinterface

// File: rtl/axi_burst_write_master.sv
// rtl/axi_burst_write_master.sv - stream-to-memory job engine issuing 4 KiB-safe AXI4 INCR write bursts
module axi_burst_write_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_MAX_BURST_LEN    = 64,
  parameter int C_MAX_OUTSTANDING  = 8,
  parameter int C_FIFO_DEPTH       = 128
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          ctrl_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
  output logic                          ctrl_busy,
  output logic                          ctrl_done,
  output logic                          ctrl_error,
  axi_burst_write_master_if.master      bus
);
  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int XW    = C_XFER_SIZE_WIDTH;
  localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int FAW   = $clog2(C_FIFO_DEPTH);
  localparam int CW    = FAW + 1;
  localparam int QW    = (C_MAX_OUTSTANDING > 1) ? $clog2(C_MAX_OUTSTANDING) : 1;
  localparam int OW    = $clog2(C_MAX_OUTSTANDING) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [AW-1:0]    addr;
  logic [XW-1:0]    aw_left, w_left, rx_left;
  logic [BYTES-1:0] last_strb;
  logic             error_q;
  logic [OW-1:0]    outstanding;
  logic [CW-1:0]    fifo_count, committed;
  logic [FAW-1:0]   fifo_wr, fifo_rd;
  logic [C_M_AXI_DATA_WIDTH-1:0] fifo_mem [C_FIFO_DEPTH];
  logic [7:0]       len_q [2**QW];
  logic [QW-1:0]    lq_wr, lq_rd;
  logic [7:0]       w_beat;

  logic [12:0] page_beats, cap_beats, burst_beats;
  logic [7:0]  awlen_c;
  logic        aw_valid, aw_hs, w_valid, w_last, w_hs, b_hs, s_ready, s_hs, start_ok;
  logic [XW-1:0]    total_c;
  logic [BYTES-1:0] last_strb_c;

  // Burst length is clipped by the remaining job, the burst cap and the next 4 KiB page edge.
  assign page_beats  = (13'h1000 - {1'b0, addr[11:0]}) >> SZ;
  assign cap_beats   = (page_beats < 13'(C_MAX_BURST_LEN)) ? page_beats : 13'(C_MAX_BURST_LEN);
  assign burst_beats = (aw_left < XW'(cap_beats)) ? aw_left[12:0] : cap_beats;
  assign awlen_c     = 8'(burst_beats - 13'd1);

  assign start_ok    = (state == IDLE) && ctrl_start;
  assign total_c     = (ctrl_xfer_size_in_bytes >> SZ) + XW'(|ctrl_xfer_size_in_bytes[SZ-1:0]);
  assign last_strb_c = (ctrl_xfer_size_in_bytes[SZ-1:0] == '0) ? '1
                     : ~({BYTES{1'b1}} << ctrl_xfer_size_in_bytes[SZ-1:0]);

  assign w_valid = (committed != '0);
  assign w_last  = w_valid && (w_beat == len_q[lq_rd]);
  assign s_ready = (state != IDLE) && (fifo_count != CW'(C_FIFO_DEPTH)) && (rx_left != '0);
  assign aw_hs   = aw_valid && bus.m_axi_awready;
  assign w_hs    = w_valid && bus.m_axi_wready;
  assign b_hs    = bus.m_axi_bvalid && bus.m_axi_bready && (outstanding != '0);
  assign s_hs    = bus.s_axis_tvalid && s_ready;

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    aw_valid = 1'b0;
    case (state)
      IDLE:  if (ctrl_start) state_nx = (ctrl_xfer_size_in_bytes == '0) ? DRAIN : RUN;
      RUN: begin
        // Only buffered beats not already promised to earlier bursts may back a new AW.
        aw_valid = (outstanding < OW'(C_MAX_OUTSTANDING))
                && (32'(fifo_count - committed) >= 32'(burst_beats));
        if (aw_valid && bus.m_axi_awready && (XW'(burst_beats) == aw_left)) state_nx = DRAIN;
      end
      DRAIN: if ((outstanding == '0) && (w_left == '0)) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      addr        <= '0;
      aw_left     <= '0;
      w_left      <= '0;
      rx_left     <= '0;
      last_strb   <= '0;
      error_q     <= 1'b0;
      outstanding <= '0;
      fifo_count  <= '0;
      committed   <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      lq_wr       <= '0;
      lq_rd       <= '0;
      w_beat      <= '0;
    end else begin
      if (start_ok) begin
        addr      <= ctrl_addr_offset & ~AW'(BYTES - 1);
        aw_left   <= total_c;
        w_left    <= total_c;
        rx_left   <= total_c;
        last_strb <= last_strb_c;
        error_q   <= 1'b0;
      end else begin
        if (aw_hs) begin
          addr    <= addr + (AW'(burst_beats) << SZ);
          aw_left <= aw_left - XW'(burst_beats);
        end
        if (w_hs) w_left  <= w_left - XW'(1);
        if (s_hs) rx_left <= rx_left - XW'(1);
        if (b_hs && (bus.m_axi_bresp != 2'b00)) error_q <= 1'b1;
      end
      if (aw_hs && !b_hs)      outstanding <= outstanding + OW'(1);
      else if (!aw_hs && b_hs) outstanding <= outstanding - OW'(1);
      fifo_count <= fifo_count + CW'(s_hs) - CW'(w_hs);
      committed  <= committed + (aw_hs ? CW'(burst_beats) : '0) - CW'(w_hs);
      fifo_wr    <= fifo_wr + FAW'(s_hs);
      fifo_rd    <= fifo_rd + FAW'(w_hs);
      lq_wr      <= lq_wr + QW'(aw_hs);
      if (w_hs) begin
        if (w_last) begin
          w_beat <= '0;
          lq_rd  <= lq_rd + QW'(1);
        end else begin
          w_beat <= w_beat + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (s_hs)  fifo_mem[fifo_wr] <= bus.s_axis_tdata;
    if (aw_hs) len_q[lq_wr]      <= awlen_c;
  end

  assign bus.m_axi_awvalid = aw_valid;
  assign bus.m_axi_awaddr  = addr;
  assign bus.m_axi_awlen   = aw_valid ? awlen_c : '0;
  assign bus.m_axi_wvalid  = w_valid;
  assign bus.m_axi_wdata   = w_valid ? fifo_mem[fifo_rd] : '0;
  assign bus.m_axi_wstrb   = !w_valid ? '0 : (w_left == XW'(1)) ? last_strb : '1;
  assign bus.m_axi_wlast   = w_last;
  assign bus.m_axi_bready  = areset;
  assign bus.s_axis_tready = s_ready;
  assign ctrl_busy         = (state != IDLE);
  assign ctrl_done         = (state == DONE);
  assign ctrl_error        = error_q;
endmodule

// File: tb/tb_axi_burst_write_master.sv
// tb/tb_axi_burst_write_master.sv - scoreboard bench: random throttling, burst/strobe model, byte memory image
module tb_axi_burst_write_master;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int XW = 32;
  localparam int LIMIT = 30000;

  logic aclk = 1'b0;
  logic areset = 1'b0;
  logic ctrl_start = 1'b0;
  logic [AW-1:0] ctrl_addr_offset = '0;
  logic [XW-1:0] ctrl_xfer_size_in_bytes = '0;
  logic ctrl_busy, ctrl_done, ctrl_error;

  always #5 aclk = ~aclk;

  axi_burst_write_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_burst_write_master #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_XFER_SIZE_WIDTH(XW),
    .C_MAX_BURST_LEN(64), .C_MAX_OUTSTANDING(2), .C_FIFO_DEPTH(128)
  ) dut (
    .aclk(aclk), .areset(areset), .ctrl_start(ctrl_start),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
    .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .ctrl_error(ctrl_error), .bus(bus)
  );

  typedef struct { logic [63:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [63:0] data; logic [7:0] strb; logic last; } w_t;

  aw_t exp_aw[$];
  w_t  exp_w[$];
  aw_t acc_aw[$];
  int  acc_idx[$];
  logic [1:0]  b_pend[$];
  logic [63:0] stream_q[$];
  logic [7:0]  job_bytes[$];
  logic [7:0]  mem [logic [63:0]];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, aw_total = 0, w_total = 0, wburst_total = 0, done_cnt = 0;
  int last_b_cyc = 0, done_cyc = 0, start_cyc = 0, err_burst = -1, w_beat_idx = 0;
  int thr_s = 100, thr_aw = 100, thr_w = 100, thr_b = 100;
  bit b_hold = 1'b0;
  logic aw_hs = 0, w_hs = 0, b_hs = 0, s_hs = 0;
  logic [63:0] job_a0;
  int job_size;
  aw_t mon_a, mon_e;
  w_t  mon_w;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  task automatic finish_now();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // Monitor: every handshake is judged on the falling edge before the rising edge that completes it.
  always @(negedge aclk) begin
    cyc++;
    if (!areset) begin
      aw_hs = 0; w_hs = 0; b_hs = 0; s_hs = 0; w_beat_idx = 0;
    end else begin
      aw_hs = bus.m_axi_awvalid && bus.m_axi_awready;
      w_hs  = bus.m_axi_wvalid && bus.m_axi_wready;
      b_hs  = bus.m_axi_bvalid && bus.m_axi_bready;
      s_hs  = bus.s_axis_tvalid && bus.s_axis_tready;
      if (ctrl_start && !ctrl_busy) start_cyc = cyc;
      if (ctrl_done) begin done_cnt++; done_cyc = cyc; end
      if (b_hs) last_b_cyc = cyc;
      if (aw_hs) begin
        mon_a.addr = bus.m_axi_awaddr;
        mon_a.len  = bus.m_axi_awlen;
        chk("aw_4k_cross", int'(mon_a.addr[11:0]) + (int'(mon_a.len) + 1) * 8 <= 4096, 1);
        if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
        else begin
          mon_e = exp_aw.pop_front();
          chk("awaddr", mon_a.addr, mon_e.addr);
          chk("awlen", mon_a.len, mon_e.len);
        end
        acc_aw.push_back(mon_a);
        acc_idx.push_back(aw_total);
        aw_total++;
      end
      if (w_hs) begin
        w_total++;
        if (acc_aw.size() == 0) chk("w_before_aw", 0, 1);
        else begin
          for (int b = 0; b < 8; b++)
            if (bus.m_axi_wstrb[b])
              mem[acc_aw[0].addr + 64'(w_beat_idx * 8 + b)] = bus.m_axi_wdata[8*b +: 8];
          if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
          else begin
            mon_w = exp_w.pop_front();
            chk("wdata", bus.m_axi_wdata, mon_w.data);
            chk("wstrb", bus.m_axi_wstrb, mon_w.strb);
            chk("wlast", bus.m_axi_wlast, mon_w.last);
          end
          if (bus.m_axi_wlast) begin
            chk("wlast_beats", w_beat_idx, acc_aw[0].len);
            b_pend.push_back((acc_idx[0] == err_burst) ? 2'b10 : 2'b00);
            void'(acc_aw.pop_front());
            void'(acc_idx.pop_front());
            w_beat_idx = 0;
            wburst_total++;
          end else w_beat_idx++;
        end
      end
    end
  end

  initial begin
    bus.s_axis_tvalid = 0; bus.s_axis_tdata = '0;
    forever begin
      @(posedge aclk); #1;
      if (!areset) bus.s_axis_tvalid = 0;
      else begin
        if (s_hs) begin void'(stream_q.pop_front()); bus.s_axis_tvalid = 0; end
        if (!bus.s_axis_tvalid && stream_q.size() != 0 && $urandom_range(99) < thr_s) begin
          bus.s_axis_tvalid = 1;
          bus.s_axis_tdata  = stream_q[0];
        end
      end
    end
  end

  initial begin
    bus.m_axi_awready = 0; bus.m_axi_wready = 0;
    forever begin
      @(posedge aclk); #1;
      bus.m_axi_awready = areset && ($urandom_range(99) < thr_aw);
      bus.m_axi_wready  = areset && ($urandom_range(99) < thr_w);
    end
  end

  initial begin
    bus.m_axi_bvalid = 0; bus.m_axi_bresp = 2'b00;
    forever begin
      @(posedge aclk); #1;
      if (!areset) bus.m_axi_bvalid = 0;
      else begin
        if (b_hs) begin void'(b_pend.pop_front()); bus.m_axi_bvalid = 0; end
        if (!bus.m_axi_bvalid && b_pend.size() != 0 && !b_hold && $urandom_range(99) < thr_b) begin
          bus.m_axi_bvalid = 1;
          bus.m_axi_bresp  = b_pend[0];
        end
      end
    end
  end

  // Reference model: split the job into page- and cap-limited bursts with plain arithmetic.
  task automatic start_job(input logic [63:0] off, input int size, input int err_idx);
    int beats, rem, i, n, pg;
    logic [63:0] a, d;
    logic [7:0] ls;
    logic [63:0] sb[$];
    aw_t e;
    w_t we;
    beats = (size + 7) / 8;
    rem = size % 8;
    ls = (rem == 0) ? 8'hff : 8'((1 << rem) - 1);
    job_a0 = off & ~64'h7;
    job_size = size;
    mem.delete();
    job_bytes.delete();
    done_cnt = 0;
    err_burst = (err_idx < 0) ? -1 : aw_total + err_idx;
    for (int k = 0; k < beats; k++) begin
      d = {$urandom, $urandom};
      sb.push_back(d);
      stream_q.push_back(d);
      for (int b = 0; b < 8; b++) job_bytes.push_back(d[8*b +: 8]);
    end
    a = job_a0;
    i = 0;
    while (i < beats) begin
      n = beats - i;
      pg = (4096 - int'(a[11:0])) / 8;
      if (n > 64) n = 64;
      if (n > pg) n = pg;
      e.addr = a; e.len = 8'(n - 1);
      exp_aw.push_back(e);
      for (int k = 0; k < n; k++) begin
        we.data = sb[i + k];
        we.strb = (i + k == beats - 1) ? ls : 8'hff;
        we.last = (k == n - 1);
        exp_w.push_back(we);
      end
      a += 64'(n * 8);
      i += n;
    end
    @(posedge aclk); #1;
    ctrl_start = 1; ctrl_addr_offset = off; ctrl_xfer_size_in_bytes = XW'(size);
    @(posedge aclk); #1;
    ctrl_start = 0;
    @(negedge aclk);
    chk("busy_after_start", ctrl_busy, 1);
    chk("error_cleared_on_start", ctrl_error, 0);
  endtask

  task automatic wait_done(input bit exp_err);
    int n, bad;
    n = 0;
    while (!ctrl_done && n < LIMIT) begin @(negedge aclk); n++; end
    chk("done_within_bound", ctrl_done, 1);
    if (!ctrl_done) finish_now();
    chk("error_at_done", ctrl_error, exp_err);
    @(negedge aclk);
    chk("done_single_pulse", done_cnt, 1);
    chk("idle_after_done", ctrl_busy, 0);
    chk("aw_all_issued", exp_aw.size(), 0);
    chk("w_all_sent", exp_w.size(), 0);
    bad = 0;
    for (int k = 0; k < job_size; k++)
      if (!mem.exists(job_a0 + 64'(k)) || mem[job_a0 + 64'(k)] !== job_bytes[k]) bad++;
    chk("mem_bytes_wrong", bad, 0);
    chk("mem_bytes_written", mem.num(), job_size);
  endtask

  task automatic set_thr(input int s, input int a, input int w, input int b);
    thr_s = s; thr_aw = a; thr_w = w; thr_b = b;
  endtask

  initial begin
    int aw0, wb0, wt0, n;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awvalid", bus.m_axi_awvalid, 0);
    chk("rst_wvalid", bus.m_axi_wvalid, 0);
    chk("rst_bready", bus.m_axi_bready, 0);
    chk("rst_tready", bus.s_axis_tready, 0);
    chk("rst_busy", ctrl_busy, 0);
    chk("rst_done", ctrl_done, 0);
    chk("rst_error", ctrl_error, 0);
    @(posedge aclk); #2 areset = 1;
    @(negedge aclk);
    chk("bready_out_of_reset", bus.m_axi_bready, 1);

    start_job(64'h1000, 512, -1);
    wait_done(0);
    chk("done_two_edges_after_b", done_cyc - last_b_cyc, 2);
    start_job(64'h1FC0, 256, -1);
    wait_done(0);
    start_job(64'h3000, 1000, -1);
    wait_done(0);
    start_job(64'h5008, 1003, -1);
    wait_done(0);

    b_hold = 1;
    aw0 = aw_total; wb0 = wburst_total;
    start_job(64'h0, 65536, 1);
    n = 0;
    while (wburst_total - wb0 < 2 && n < 2000) begin @(negedge aclk); n++; end
    chk("two_bursts_written", wburst_total - wb0 >= 2, 1);
    repeat (30) @(negedge aclk);
    chk("aw_count_at_max_outstanding", aw_total - aw0, 2);
    chk("awvalid_low_at_max_outstanding", bus.m_axi_awvalid, 0);
    b_hold = 0;
    n = 0;
    while (aw_total - aw0 < 3 && n < 2000) begin @(negedge aclk); n++; end
    chk("third_aw_after_b", aw_total - aw0 >= 3, 1);
    wait_done(1);
    start_job(64'h7000, 200, -1);
    wait_done(0);

    for (int j = 0; j < 10; j++) begin
      set_thr($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 30));
      start_job({40'h0, 8'($urandom_range(255)), 4'h0, 12'($urandom)}, $urandom_range(4000, 1), -1);
      wait_done(0);
    end
    set_thr(100, 100, 100, 100);

    wt0 = w_total;
    start_job(64'h1000, 512, -1);
    n = 0;
    while (w_total - wt0 < 20 && n < 2000) begin @(negedge aclk); n++; end
    @(posedge aclk); #2 areset = 0;
    #1;
    chk("abort_awvalid", bus.m_axi_awvalid, 0);
    chk("abort_wvalid", bus.m_axi_wvalid, 0);
    chk("abort_wlast", bus.m_axi_wlast, 0);
    chk("abort_bready", bus.m_axi_bready, 0);
    chk("abort_tready", bus.s_axis_tready, 0);
    chk("abort_busy", ctrl_busy, 0);
    chk("abort_done", ctrl_done, 0);
    stream_q.delete(); exp_aw.delete(); exp_w.delete();
    acc_aw.delete(); acc_idx.delete(); b_pend.delete();
    repeat (3) @(posedge aclk);
    #2 areset = 1;
    start_job(64'h1000, 512, -1);
    wait_done(0);

    aw0 = aw_total;
    start_job(64'h2000, 0, -1);
    wait_done(0);
    chk("zero_size_done_latency", done_cyc - start_cyc, 2);
    chk("zero_size_no_aw", aw_total - aw0, 0);
    finish_now();
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    finish_now();
  end
endmodule
